// File: rtl/write_vels_queue.sv
// write_vels_queue: buffered face-velocity writer.
//
// Per-cell updates arrive over a valid/ready handshake and are held in a small FIFO.
// An engine pops one cell at a time and writes its four faces into the horizontal and
// vertical velocity BRAMs. There are two phases per cell:
//   A phase: left face (vx1) and top face (vy1)
//   B phase: right face (vx2) and bottom face (vy2)
// Faces on the field boundary and faces with a clear mask bit are not written. A phase
// that has no face to write takes no cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   update handshake (in_ready = FIFO not full)
//   in_x, in_y          cell coordinates
//   in_mask             face enables {vy2, vy1, vx2, vx1}
//   in_vx1..in_vy2      face words (wall bit + velocity)
//   h_vel_*             horizontal-face BRAM write port (registered)
//   v_vel_*             vertical-face BRAM write port (registered)
//   done                one-cycle pulse when an entry retires
//   idle                FIFO empty and engine idle
//   err                 sticky out-of-range flag
//
// Optional feature: define WRITE_VELS_QUEUE_RANGE_CHECK_EN to drop entries whose
// coordinates fall outside the field and to raise the sticky err flag. Without it, err
// is tied low.
module write_vels_queue #(
    parameter int unsigned FIELD_WIDTH  = 8,
    parameter int unsigned FIELD_HEIGHT = 6,
    parameter int unsigned VEL_DATAW    = 33,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned X_W         = $clog2(FIELD_WIDTH),
    localparam int unsigned Y_W         = $clog2(FIELD_HEIGHT),
    localparam int unsigned H_VEL_ADDRW = $clog2((FIELD_WIDTH - 1) * FIELD_HEIGHT),
    localparam int unsigned V_VEL_ADDRW = $clog2(FIELD_WIDTH * (FIELD_HEIGHT - 1))
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_W-1:0]         in_x,
    input  logic [Y_W-1:0]         in_y,
    input  logic [3:0]             in_mask,
    input  logic [VEL_DATAW-1:0]   in_vx1,
    input  logic [VEL_DATAW-1:0]   in_vx2,
    input  logic [VEL_DATAW-1:0]   in_vy1,
    input  logic [VEL_DATAW-1:0]   in_vy2,
    output logic [H_VEL_ADDRW-1:0] h_vel_addr_write,
    output logic [VEL_DATAW-1:0]   h_vel_data_in,
    output logic                   h_vel_we,
    output logic [V_VEL_ADDRW-1:0] v_vel_addr_write,
    output logic [VEL_DATAW-1:0]   v_vel_data_in,
    output logic                   v_vel_we,
    output logic                   done,
    output logic                   idle,
    output logic                   err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [X_W-1:0]       x;
        logic [Y_W-1:0]       y;
        logic [3:0]           mask;
        logic [VEL_DATAW-1:0] vx1;
        logic [VEL_DATAW-1:0] vx2;
        logic [VEL_DATAW-1:0] vy1;
        logic [VEL_DATAW-1:0] vy2;
    } entry_t;

    // StPhaseA: A-phase writes are on the outputs and the B phase is still owed.
    // StLast:   the entry's final beat (with done) is on the outputs; a new entry may be
    //           popped on the next edge, which keeps back-to-back entries bubble-free.
    typedef enum logic [1:0] {StIdle, StPhaseA, StLast} state_e;

    function automatic logic a_h_ok(input entry_t e);
        return (e.x != '0) && e.mask[0];
    endfunction

    function automatic logic a_v_ok(input entry_t e);
        return (e.y != '0) && e.mask[2];
    endfunction

    function automatic logic b_h_ok(input entry_t e);
        return (32'(e.x) != FIELD_WIDTH - 1) && e.mask[1];
    endfunction

    function automatic logic b_v_ok(input entry_t e);
        return (32'(e.y) != FIELD_HEIGHT - 1) && e.mask[3];
    endfunction

    function automatic logic [H_VEL_ADDRW-1:0] h_addr(input int unsigned x, input int unsigned y);
        return H_VEL_ADDRW'(x + y * (FIELD_WIDTH - 1));
    endfunction

    function automatic logic [V_VEL_ADDRW-1:0] v_addr(input int unsigned x, input int unsigned y);
        return V_VEL_ADDRW'(x + y * FIELD_WIDTH);
    endfunction

    // ---------------- FIFO ----------------
    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, push, pop;
    entry_t           in_entry, head;

    assign in_entry = {in_x, in_y, in_mask, in_vx1, in_vx2, in_vy1, in_vy2};
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- Engine ----------------
    state_e                 state_q, state_d;
    entry_t                 work_q, work_d, cur;
    logic                   issue_a, issue_b, drop;
    logic                   h_we_d, v_we_d, done_d;
    logic [H_VEL_ADDRW-1:0] h_addr_d;
    logic [V_VEL_ADDRW-1:0] v_addr_d;
    logic [VEL_DATAW-1:0]   h_data_d, v_data_d;

    always_comb begin
        state_d  = StIdle;
        work_d   = work_q;
        cur      = head;
        pop      = 1'b0;
        drop     = 1'b0;
        issue_a  = 1'b0;
        issue_b  = 1'b0;
        done_d   = 1'b0;
        h_we_d   = 1'b0;
        v_we_d   = 1'b0;
        h_addr_d = h_vel_addr_write;
        h_data_d = h_vel_data_in;
        v_addr_d = v_vel_addr_write;
        v_data_d = v_vel_data_in;

        if (state_q == StPhaseA) begin
            cur     = work_q;
            issue_b = 1'b1;
            done_d  = 1'b1;
            state_d = StLast;
        end else if (!empty) begin
            pop    = 1'b1;
            work_d = head;
`ifdef WRITE_VELS_QUEUE_RANGE_CHECK_EN
            drop = (32'(head.x) >= FIELD_WIDTH) || (32'(head.y) >= FIELD_HEIGHT);
`endif
            state_d = StLast;
            if (drop || !(a_h_ok(head) || a_v_ok(head) || b_h_ok(head) || b_v_ok(head))) begin
                // Nothing to write: retire with a bare done pulse.
                done_d = 1'b1;
            end else if (a_h_ok(head) || a_v_ok(head)) begin
                issue_a = 1'b1;
                if (b_h_ok(head) || b_v_ok(head)) begin
                    state_d = StPhaseA;
                end else begin
                    done_d = 1'b1;
                end
            end else begin
                issue_b = 1'b1;
                done_d  = 1'b1;
            end
        end

        if (issue_a) begin
            h_we_d = a_h_ok(cur);
            v_we_d = a_v_ok(cur);
            if (h_we_d) begin
                h_addr_d = h_addr(32'(cur.x) - 32'd1, 32'(cur.y));
                h_data_d = cur.vx1;
            end
            if (v_we_d) begin
                v_addr_d = v_addr(32'(cur.x), 32'(cur.y) - 32'd1);
                v_data_d = cur.vy1;
            end
        end
        if (issue_b) begin
            h_we_d = b_h_ok(cur);
            v_we_d = b_v_ok(cur);
            if (h_we_d) begin
                h_addr_d = h_addr(32'(cur.x), 32'(cur.y));
                h_data_d = cur.vx2;
            end
            if (v_we_d) begin
                v_addr_d = v_addr(32'(cur.x), 32'(cur.y));
                v_data_d = cur.vy2;
            end
        end
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            h_vel_we         <= 1'b0;
            v_vel_we         <= 1'b0;
            done             <= 1'b0;
            h_vel_addr_write <= '0;
            h_vel_data_in    <= '0;
            v_vel_addr_write <= '0;
            v_vel_data_in    <= '0;
        end else begin
            state_q          <= state_d;
            h_vel_we         <= h_we_d;
            v_vel_we         <= v_we_d;
            done             <= done_d;
            h_vel_addr_write <= h_addr_d;
            h_vel_data_in    <= h_data_d;
            v_vel_addr_write <= v_addr_d;
            v_vel_data_in    <= v_data_d;
        end
    end

    assign idle = empty && (state_q == StIdle);

`ifdef WRITE_VELS_QUEUE_RANGE_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (pop && drop) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
